// File: rtl/fsab_req_arbiter.sv
// fsab_req_arbiter: shares one FSAB outbound request port between NREQ requesters.
// Each requester has a private QDEPTH-entry queue; queues drain round-robin while
// upstream fabric credits are available. Requesters get one credit back per grant.
// Optional build macro FSAB_ARB_STATS_EN adds per-requester grant counters and a
// credit-stall cycle counter.
module fsab_req_arbiter #(
  parameter int unsigned NREQ                 = 2,
  parameter int unsigned QDEPTH               = 4,
  parameter int unsigned FSAB_INITIAL_CREDITS = 4,
  parameter int unsigned UP_CREDITS           = FSAB_INITIAL_CREDITS,
  parameter int unsigned FSAB_REQ_HI          = 0,
  parameter int unsigned FSAB_DID_HI          = 3,
  parameter int unsigned FSAB_ADDR_HI         = 31,
  parameter int unsigned FSAB_LEN_HI          = 2,
  parameter int unsigned FSAB_DATA_HI         = 63,
  parameter int unsigned FSAB_MASK_HI         = 7,
  parameter int unsigned ENTRY_W              = FSAB_REQ_HI + 1 + 2 * (FSAB_DID_HI + 1) +
                                                FSAB_ADDR_HI + 1 + FSAB_LEN_HI + 1 +
                                                FSAB_DATA_HI + 1 + FSAB_MASK_HI + 1
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [NREQ-1:0]         rq_valid,
  input  logic [NREQ*ENTRY_W-1:0] rq_entry,
  output logic [NREQ-1:0]         rq_credit,
  output logic                    fsabo_valid,
  output logic [ENTRY_W-1:0]      fsabo_entry,
  input  logic                    fsabo_credit,
  output logic [NREQ-1:0]         arb_overflow,
  output logic                    arb_busy
`ifdef FSAB_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]      arb_stat_grants,
  output logic [15:0]             arb_stat_stall
`endif
);

  localparam int unsigned AW  = $clog2(QDEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW  = RRW + 1;
  localparam int unsigned UCW = $clog2(UP_CREDITS + 1);

  logic [ENTRY_W-1:0] mem_q    [NREQ][QDEPTH];
  logic [ENTRY_W-1:0] mem_d    [NREQ][QDEPTH];
  logic [PW-1:0]      wr_ptr_q [NREQ];
  logic [PW-1:0]      wr_ptr_d [NREQ];
  logic [PW-1:0]      rd_ptr_q [NREQ];
  logic [PW-1:0]      rd_ptr_d [NREQ];
  logic [RRW-1:0]     rr_q, rr_d;
  logic [UCW-1:0]     up_credits_q, up_credits_d;
  logic               fsabo_valid_q, fsabo_valid_d;
  logic [ENTRY_W-1:0] fsabo_entry_q, fsabo_entry_d;
  logic [NREQ-1:0]    rq_credit_q, rq_credit_d;
  logic [NREQ-1:0]    arb_overflow_q, arb_overflow_d;
  logic               arb_busy_q, arb_busy_d;

  logic [NREQ-1:0]    empty_c;
  logic [NREQ-1:0]    full_c;
  logic [NREQ-1:0]    deq_c;
  logic               grant_c;
  logic [RRW-1:0]     winner_c;

  // Queue status from pointer comparison (extra MSB distinguishes full from empty).
  always_comb begin
    empty_c = '0;
    full_c  = '0;
    for (int i = 0; i < NREQ; i++) begin
      empty_c[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_c[i]  = (wr_ptr_q[i][PW-1] != rd_ptr_q[i][PW-1]) &&
                   (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
  end

  // Round-robin pick: first non-empty queue at or above rr pointer, wrapping at NREQ.
  always_comb begin
    logic [SW-1:0] idx_sum;
    logic          found;
    idx_sum  = '0;
    found    = 1'b0;
    winner_c = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_sum = SW'(rr_q) + SW'(k);
      if (idx_sum >= SW'(NREQ)) idx_sum = idx_sum - SW'(NREQ);
      if (!found && !empty_c[idx_sum[RRW-1:0]]) begin
        winner_c = idx_sum[RRW-1:0];
        found    = 1'b1;
      end
    end
    grant_c = (|(~empty_c)) && (up_credits_q != '0);
    deq_c   = '0;
    for (int i = 0; i < NREQ; i++) begin
      deq_c[i] = grant_c && (winner_c == RRW'(i));
    end
  end

  // Enqueue/dequeue; a full queue still accepts when its head leaves on the same edge.
  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    arb_overflow_d = arb_overflow_q;
    arb_busy_d     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (deq_c[i]) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      if (rq_valid[i]) begin
        if (!full_c[i] || deq_c[i]) begin
          mem_d[i][wr_ptr_q[i][AW-1:0]] = rq_entry[i*ENTRY_W +: ENTRY_W];
          wr_ptr_d[i]                   = wr_ptr_q[i] + PW'(1);
        end else begin
          arb_overflow_d[i] = 1'b1;
        end
      end
      if (wr_ptr_d[i] != rd_ptr_d[i]) arb_busy_d = 1'b1;
    end
  end

  // Shared port, requester credit return, rr pointer and upstream credit count.
  always_comb begin
    logic [SW-1:0] rr_nxt;
    rr_nxt        = SW'(winner_c) + SW'(1);
    if (rr_nxt >= SW'(NREQ)) rr_nxt = '0;
    rr_d          = grant_c ? rr_nxt[RRW-1:0] : rr_q;
    fsabo_valid_d = grant_c;
    fsabo_entry_d = grant_c ? mem_q[winner_c][rd_ptr_q[winner_c][AW-1:0]] : fsabo_entry_q;
    rq_credit_d   = deq_c;
    up_credits_d  = up_credits_q + UCW'(fsabo_credit) - UCW'(grant_c);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NREQ; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        for (int j = 0; j < QDEPTH; j++) mem_q[i][j] <= '0;
      end
      rr_q           <= '0;
      up_credits_q   <= UCW'(UP_CREDITS);
      fsabo_valid_q  <= 1'b0;
      fsabo_entry_q  <= '0;
      rq_credit_q    <= '0;
      arb_overflow_q <= '0;
      arb_busy_q     <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rr_q           <= rr_d;
      up_credits_q   <= up_credits_d;
      fsabo_valid_q  <= fsabo_valid_d;
      fsabo_entry_q  <= fsabo_entry_d;
      rq_credit_q    <= rq_credit_d;
      arb_overflow_q <= arb_overflow_d;
      arb_busy_q     <= arb_busy_d;
    end
  end

  assign fsabo_valid  = fsabo_valid_q;
  assign fsabo_entry  = fsabo_entry_q;
  assign rq_credit    = rq_credit_q;
  assign arb_overflow = arb_overflow_q;
  assign arb_busy     = arb_busy_q;

`ifdef FSAB_ARB_STATS_EN
  logic [15:0] stat_grants_q [NREQ];
  logic [15:0] stat_grants_d [NREQ];
  logic [15:0] stat_stall_q, stat_stall_d;

  // Saturating grant and credit-stall counters.
  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_stall_d  = stat_stall_q;
    for (int i = 0; i < NREQ; i++) begin
      if (deq_c[i] && (stat_grants_q[i] != 16'hFFFF)) stat_grants_d[i] = stat_grants_q[i] + 16'd1;
    end
    if ((|(~empty_c)) && (up_credits_q == '0) && (stat_stall_q != 16'hFFFF)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NREQ; i++) stat_grants_q[i] <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  // Flatten grant counters onto the output bus.
  always_comb begin
    arb_stat_grants = '0;
    for (int i = 0; i < NREQ; i++) arb_stat_grants[i*16 +: 16] = stat_grants_q[i];
  end

  assign arb_stat_stall = stat_stall_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
